// File: rtl/compare_bank_if.sv
// compare_bank_if: host register-write bus for compare_bank.
// The host drives the master side; compare_bank samples the slave side on each clock edge.
interface compare_bank_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_en;    // one write per cycle
  logic             wr_sel;   // 0: compare register, 1: period register
  logic [CH_W-1:0]  wr_chan;  // target channel; out-of-range values are ignored
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_sel,
    output wr_chan,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_sel,
    input wr_chan,
    input wr_data
  );
endinterface

// File: rtl/compare_bank.sv
// compare_bank: NUM_CH compare channels checked against a shared free-running counter.
// Each channel keeps a sticky match flag and can auto-advance its compare value by a period.
// Masked flags are ORed into a single irq.
// Optional feature: define COMPARE_BANK_MATCH_COUNT_EN to add per-channel saturating hit
// counters and the match_count output.
module compare_bank #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        counter,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       irq_mask,
  compare_bank_if.slave           wr,
  output logic [NUM_CH-1:0]       match,
  output logic                    irq
`ifdef COMPARE_BANK_MATCH_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] match_count
`endif
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1) begin : g_bad_params
    $error("compare_bank: NUM_CH must be 1..16 and CNT_W at least 1");
  end

  logic [WIDTH-1:0]  cmp_q    [NUM_CH];
  logic [WIDTH-1:0]  cmp_d    [NUM_CH];
  logic [WIDTH-1:0]  period_q [NUM_CH];
  logic [WIDTH-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] match_q;
  logic [NUM_CH-1:0] match_d;
  logic [NUM_CH-1:0] hit;
  logic              wr_ok;

  // Writes to channels that do not exist are dropped without side effects.
  assign wr_ok = wr.wr_en && (32'(wr.wr_chan) < NUM_CH);

  // Per-channel hit detection, reload, host write and sticky flag next state.
  always_comb begin
    hit     = '0;
    match_d = match_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cmp_d[i]    = cmp_q[i];
      period_d[i] = period_q[i];
      hit[i]      = enable[i] && (counter == cmp_q[i]);
      // Reload reads the old period, so a same-cycle period write lands afterwards.
      if (hit[i] && periodic[i]) begin
        cmp_d[i] = cmp_q[i] + period_q[i];
      end
      // Host write to cmp overrides a simultaneous reload.
      if (wr_ok && (wr.wr_chan == CH_W'(i))) begin
        if (wr.wr_sel) begin
          period_d[i] = wr.wr_data;
        end else begin
          cmp_d[i] = wr.wr_data;
        end
      end
      // Hit beats clear.
      if (hit[i]) begin
        match_d[i] = 1'b1;
      end else if (clear[i]) begin
        match_d[i] = 1'b0;
      end
    end
  end

  // Compare, period and flag registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cmp_q[i]    <= '0;
        period_q[i] <= '0;
      end
      match_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cmp_q[i]    <= cmp_d[i];
        period_q[i] <= period_d[i];
      end
      match_q <= match_d;
    end
  end

  assign match = match_q;
  assign irq   = |(match_q & irq_mask);

`ifdef COMPARE_BANK_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Saturating hit counters; a hit with a clear restarts the count at one.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (hit[i]) begin
        if (clear[i]) begin
          cnt_d[i] = CNT_W'(1);
        end else if (!(&cnt_q[i])) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (clear[i]) begin
        cnt_d[i] = '0;
      end
    end
  end

  // Hit counter registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt_out
    assign match_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_compare_bank.sv
// tb_compare_bank: table-driven and directed checks plus a randomized run against a
// rule-level reference model. A second, narrow instance exercises out-of-range writes.
module tb_compare_bank;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned S_WIDTH  = 8;
  localparam int unsigned S_NUM_CH = 3;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  counter;
  logic [NUM_CH-1:0] enable, periodic, clear, irq_mask, match;
  logic              irq;
  logic [S_WIDTH-1:0]  s_counter;
  logic [S_NUM_CH-1:0] s_enable, s_periodic, s_clear, s_irq_mask, s_match;
  logic                s_irq;

  compare_bank_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) wr_bus ();
  compare_bank_if #(.WIDTH(S_WIDTH), .NUM_CH(S_NUM_CH)) s_wr_bus ();

`ifdef COMPARE_BANK_MATCH_COUNT_EN
  logic [NUM_CH*CNT_W-1:0]   match_count;
  logic [S_NUM_CH*CNT_W-1:0] s_match_count;
`endif

  compare_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .counter  (counter),
    .enable   (enable),
    .periodic (periodic),
    .clear    (clear),
    .irq_mask (irq_mask),
    .wr       (wr_bus),
    .match    (match),
    .irq      (irq)
`ifdef COMPARE_BANK_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  compare_bank #(.WIDTH(S_WIDTH), .NUM_CH(S_NUM_CH), .CNT_W(CNT_W)) u_small (
    .clk_in   (clk_in),
    .reset    (reset),
    .counter  (s_counter),
    .enable   (s_enable),
    .periodic (s_periodic),
    .clear    (s_clear),
    .irq_mask (s_irq_mask),
    .wr       (s_wr_bus),
    .match    (s_match),
    .irq      (s_irq)
`ifdef COMPARE_BANK_MATCH_COUNT_EN
    ,
    .match_count (s_match_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] counter;
    logic [3:0]  enable, periodic, clear, irq_mask;
    logic        wr_en, wr_sel;
    logic [1:0]  wr_chan;
    logic [31:0] wr_data;
    logic [3:0]  exp_match;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [23];

  // Reference model state: compare/period values, flags and hit counts per channel.
  logic [31:0] m_cmp [NUM_CH];
  logic [31:0] m_per [NUM_CH];
  logic [3:0]  m_match;
  int          m_cnt [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_wr(input logic en, input logic sel, input logic [1:0] ch,
                        input logic [31:0] data);
    wr_bus.wr_en   = en;
    wr_bus.wr_sel  = sel;
    wr_bus.wr_chan = ch;
    wr_bus.wr_data = data;
  endtask

  task automatic set_ctl(input logic [31:0] c, input logic [3:0] en, input logic [3:0] per,
                         input logic [3:0] clr, input logic [3:0] msk);
    counter  = c;
    enable   = en;
    periodic = per;
    clear    = clr;
    irq_mask = msk;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    set_ctl(32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 4'hF);
    set_wr(1'b0, 1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    #2;
    tick();
    reset = 1'b1;
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      m_cmp[ch] = '0;
      m_per[ch] = '0;
      m_cnt[ch] = 0;
    end
    m_match = '0;
  endfunction

  // One clock edge of the rules, applied to the inputs currently being driven.
  function automatic void model_step();
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      bit hit;
      logic [31:0] next_cmp;
      hit = enable[ch] && (counter == m_cmp[ch]);
      next_cmp = hit && periodic[ch] ? m_cmp[ch] + m_per[ch] : m_cmp[ch];
      if (wr_bus.wr_en && int'(wr_bus.wr_chan) == ch) begin
        if (wr_bus.wr_sel) m_per[ch] = wr_bus.wr_data;
        else next_cmp = wr_bus.wr_data;
      end
      m_cmp[ch] = next_cmp;
      if (hit) begin
        m_match[ch] = 1'b1;
        m_cnt[ch] = clear[ch] ? 1 : (m_cnt[ch] < 255 ? m_cnt[ch] + 1 : 255);
      end else if (clear[ch]) begin
        m_match[ch] = 1'b0;
        m_cnt[ch] = 0;
      end
    end
  endfunction

  initial begin
    // counter, enable, periodic, clear, irq_mask, wr_en, wr_sel, wr_chan, wr_data, match, irq
    vecs[0]  = '{32'd0,   4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 32'd100, 4'h0, 1'b0};
    vecs[1]  = '{32'd98,  4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[2]  = '{32'd99,  4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[3]  = '{32'd100, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[4]  = '{32'd101, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[5]  = '{32'd102, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[6]  = '{32'd101, 4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[7]  = '{32'd100, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[8]  = '{32'd100, 4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[9]  = '{32'd101, 4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[10] = '{32'd50,  4'h5, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 2'd2, 32'd100, 4'h0, 1'b0};
    vecs[11] = '{32'd100, 4'h5, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 2'd0, 32'd0,   4'h5, 1'b0};
    vecs[12] = '{32'd50,  4'h5, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1, 32'd7,   4'h5, 1'b0};
    vecs[13] = '{32'd7,   4'h7, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 2'd0, 32'd0,   4'h7, 1'b1};
    vecs[14] = '{32'd7,   4'h0, 4'h0, 4'hF, 4'h2, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[15] = '{32'd0,   4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 32'd3,   4'h0, 1'b0};
    vecs[16] = '{32'd100, 4'h1, 4'h1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[17] = '{32'd100, 4'h1, 4'h1, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[18] = '{32'd103, 4'h1, 4'h1, 4'h1, 4'hF, 1'b1, 1'b0, 2'd0, 32'd200, 4'h1, 1'b1};
    vecs[19] = '{32'd106, 4'h1, 4'h1, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h0, 1'b0};
    vecs[20] = '{32'd200, 4'h1, 4'h1, 4'h1, 4'hF, 1'b1, 1'b1, 2'd0, 32'd50,  4'h1, 1'b1};
    vecs[21] = '{32'd203, 4'h1, 4'h1, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};
    vecs[22] = '{32'd253, 4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0,   4'h1, 1'b1};

    s_counter  = '0;
    s_enable   = '0;
    s_periodic = '0;
    s_clear    = '0;
    s_irq_mask = '1;
    s_wr_bus.wr_en   = 1'b0;
    s_wr_bus.wr_sel  = 1'b0;
    s_wr_bus.wr_chan = '0;
    s_wr_bus.wr_data = '0;

    do_reset();
    check("reset match", 32'(match), 32'h0);
    check("reset irq", 32'(irq), 32'h0);

    // One-shot, hit/clear priority, masking, write-vs-reload ordering.
    for (int i = 0; i < 23; i++) begin
      set_ctl(vecs[i].counter, vecs[i].enable, vecs[i].periodic, vecs[i].clear,
              vecs[i].irq_mask);
      set_wr(vecs[i].wr_en, vecs[i].wr_sel, vecs[i].wr_chan, vecs[i].wr_data);
      tick();
      check($sformatf("vec%0d match", i), 32'(match), 32'(vecs[i].exp_match));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end
    set_wr(1'b0, 1'b0, 2'd0, 32'd0);

    // Periodic channel 1: hits at 5, 15, 25, 35 and then at 45. Clear held high so the
    // flag shows each individual hit.
    do_reset();
    set_wr(1'b1, 1'b1, 2'd1, 32'd10);
    tick();
    set_wr(1'b1, 1'b0, 2'd1, 32'd5);
    tick();
    set_wr(1'b0, 1'b0, 2'd0, 32'd0);
    begin
      int hits = 0;
      for (int c = 0; c <= 40; c++) begin
        set_ctl(32'(c), 4'h2, 4'h2, 4'h2, 4'hF);
        tick();
        check($sformatf("periodic c=%0d", c), 32'(match[1]), 32'((c % 10) == 5));
        if (match[1]) hits++;
      end
      check("periodic hit total", 32'(hits), 32'd4);
    end
    set_ctl(32'd45, 4'h2, 4'h2, 4'h2, 4'hF);
    tick();
    check("periodic final cmp 45", 32'(match), 32'h2);

    // Channel 2 wrap-around: 0xFFFFFFF8 + 0x10 -> 0x8.
    set_wr(1'b1, 1'b0, 2'd2, 32'hFFFF_FFF8);
    set_ctl(32'd0, 4'h0, 4'h0, 4'hF, 4'hF);
    tick();
    set_wr(1'b1, 1'b1, 2'd2, 32'h10);
    tick();
    set_wr(1'b0, 1'b0, 2'd0, 32'd0);
    set_ctl(32'hFFFF_FFF8, 4'h4, 4'h4, 4'h4, 4'hF);
    tick();
    check("wrap first hit", 32'(match), 32'h4);
    tick();
    check("wrap cmp moved", 32'(match), 32'h0);
    counter = 32'h8;
    tick();
    check("wrap hit at 8", 32'(match), 32'h4);
    tick();
    check("wrap cmp now 0x18", 32'(match), 32'h0);

    // Asynchronous reset between edges.
    set_ctl(32'h18, 4'h4, 4'h0, 4'h0, 4'hF);
    tick();
    check("pre-reset match", 32'(match), 32'h4);
    check("pre-reset irq", 32'(irq), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset match", 32'(match), 32'h0);
    check("async reset irq", 32'(irq), 32'h0);
    #1;
    reset = 1'b1;
    set_ctl(32'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    tick();
    check("post-reset cmp zero", 32'(match), 32'hF);
    tick();
    check("post-reset period zero", 32'(match), 32'hF);
    set_ctl(32'h18, 4'h4, 4'h0, 4'hF, 4'hF);
    tick();
    check("post-reset cmp2 cleared", 32'(match), 32'h0);

`ifdef COMPARE_BANK_MATCH_COUNT_EN
    // Saturating counter on channel 3.
    do_reset();
    set_ctl(32'h0, 4'h8, 4'h0, 4'h8, 4'hF);
    tick();
    check("count hit+clear", 32'(match_count[3*CNT_W +: CNT_W]), 32'd1);
    clear = 4'h0;
    for (int i = 0; i < 300; i++) tick();
    check("count saturates", 32'(match_count[3*CNT_W +: CNT_W]), 32'd255);
    set_ctl(32'h5, 4'h8, 4'h0, 4'h8, 4'hF);
    tick();
    check("count cleared", 32'(match_count[3*CNT_W +: CNT_W]), 32'd0);
`endif

    // Narrow instance: wr_chan 3 does not exist and must not change anything.
    do_reset();
    for (int ch = 0; ch < 3; ch++) begin
      s_wr_bus.wr_en   = 1'b1;
      s_wr_bus.wr_sel  = 1'b0;
      s_wr_bus.wr_chan = 2'(ch);
      s_wr_bus.wr_data = 8'h10;
      tick();
    end
    s_wr_bus.wr_chan = 2'd3;
    s_wr_bus.wr_data = 8'h20;
    tick();
    s_wr_bus.wr_sel  = 1'b1;
    s_wr_bus.wr_data = 8'h05;
    tick();
    s_wr_bus.wr_en = 1'b0;
    s_enable   = 3'h7;
    s_periodic = 3'h7;
    s_counter  = 8'h20;
    tick();
    check("oob write cmp ignored", 32'(s_match), 32'h0);
    s_counter = 8'h10;
    tick();
    check("oob cmp kept", 32'(s_match), 32'h7);
    s_clear = 3'h7;
    tick();
    check("oob period kept", 32'(s_match), 32'h7);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      set_ctl(32'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
              4'($urandom) & 4'($urandom), 4'($urandom));
      set_wr(1'($urandom), 1'($urandom), 2'($urandom), 32'($urandom_range(0, 15)));
      model_step();
      tick();
      check($sformatf("rand%0d match", cyc), 32'(match), 32'(m_match));
      check($sformatf("rand%0d irq", cyc), 32'(irq), 32'(|(m_match & irq_mask)));
`ifdef COMPARE_BANK_MATCH_COUNT_EN
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        check($sformatf("rand%0d count%0d", cyc, ch),
              32'(match_count[ch*CNT_W +: CNT_W]), 32'(m_cnt[ch]));
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
